text_console_writer: RTL and testbench
======================================

TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 Parameter COLS, default 120, characters per text row.
REQ-002 Parameter ROWS, default 61, text rows in the buffer.
REQ-003 Port clk50  input  1  single clock; all logic on its rising edge.
REQ-004 Port rst_n  input  1  synchronous active-low reset, sampled on clk50 rising edge.
REQ-005 Port CharIn  input  8  character code offered upstream.
REQ-006 Port AttrIn  input  10  {BL[1:0],BG[3:0],FG[3:0]} attribute, sampled with CharIn.
REQ-007 Port CharValid  input  1  CharIn/AttrIn valid.
REQ-008 Port CharReady  output  1  block can accept a character this cycle.
REQ-009 Port WAddr  output  13  text-buffer write address, row*COLS+col.
REQ-010 Port WData  output  18  {BL,BG,FG,Char} cell word for the text buffer.
REQ-011 Port Write  output  1  one-cycle write strobe to the text buffer.
REQ-012 Port CursorCol  output  7; CursorRow  output  6  current cursor position.

Function
REQ-013 Transfer occurs on a rising edge with CharValid=1 and CharReady=1; char and attr latched, CharReady drops next cycle.
REQ-014 FSM states IDLE, SETUP, STROBE, ADVANCE, CLEAR_SETUP, CLEAR_STROBE; CharReady=1 only in IDLE.
REQ-015 Write cycle: SETUP drives WAddr/WData stable; STROBE holds them and asserts Write for exactly one cycle; WAddr/WData unchanged in cycle after Write falls.
REQ-016 Printable char (0x20-0x7E, 0x80-0xFF): IDLE->SETUP->STROBE->ADVANCE->IDLE; Write high 2 cycles after acceptance; CharReady back 4 cycles after acceptance.
REQ-017 ADVANCE after printable: col<COLS-1 -> col+1; col=COLS-1 -> col=0, row advances per REQ-020.
REQ-018 0x0D (CR): col=0, no write, IDLE->ADVANCE->IDLE.
REQ-019 0x0A (LF): col=0, row advances per REQ-020, no write of the LF itself.
REQ-020 Row advance: row<ROWS-1 -> row+1; row=ROWS-1 -> row=0 (wrap, no scroll).
REQ-021 0x08 (BS): col>0 -> col-1; col=0 -> no change; no write.
REQ-022 0x0C (FF): cursor to (0,0); whole-screen clear per REQ-030.
REQ-023 Other control codes (0x00-0x1F not listed, 0x7F): accepted and discarded, cursor unchanged, no write.
REQ-024 Address from a line-base register (row*COLS) updated by +COLS / reset to 0 on wrap; no multiplier; WAddr = base + col, 13-bit, never exceeds COLS*ROWS-1.
REQ-025 CharValid dropping while CharReady=0 has no effect; CharIn changes outside transfer ignored.

Reset
REQ-026 rst_n=0 at a rising edge: state IDLE, Write=0, WAddr=0, WData=0, CursorCol=0, CursorRow=0, CharReady=0 during reset, 1 on first cycle after rst_n=1.
REQ-027 Reset mid-write or mid-clear aborts immediately; no Write pulse after the reset edge; pending char discarded.

Configuration
REQ-028 Macro XRC_LINE_CLEAR_EN selects automatic clearing.
REQ-029 Without XRC_LINE_CLEAR_EN: row advance (wrap or LF) performs no clear; FF only homes cursor; CLEAR states absent.
REQ-030 With XRC_LINE_CLEAR_EN: every row advance clears the new row (COLS cells); FF clears ROWS*COLS cells from address 0; clear cell = {latched attr, 8'h20}; one cell per 2 cycles (CLEAR_SETUP, CLEAR_STROBE); CharReady=0 throughout; cursor unchanged by clear.

Verification
REQ-031 After reset, send 'A'(0x41), attr 10'h0F0 -> Write once, WAddr=0, WData=18'h0F041, CursorCol=1, CharReady high 4 cycles after acceptance.
REQ-032 Cursor at (119,0), send 'Z' -> write WAddr=119, then CursorCol=0, CursorRow=1; with macro, 120 writes of 0x20 at WAddr 120..239.
REQ-033 Cursor at (5,60), send LF -> CursorRow=0, CursorCol=0; with macro, clears WAddr 0..119; without macro, zero writes.
REQ-034 Cursor at (0,3), send BS then CR then 0x07 -> no Write pulses, cursor stays (0,3).
REQ-035 Send FF with macro, assert rst_n=0 after 50 clear writes -> Write=0 from the reset edge on, cursor (0,0), CharReady=1 first cycle after release.

Source files
------------

// File: rtl/text_console_writer.sv
// Character stream to text-buffer cell writes with cursor, CR/LF/BS/FF handling.
// Define XRC_LINE_CLEAR_EN to clear each newly entered row and the whole screen on form feed.
module text_console_writer #(
    parameter int COLS = 120,
    parameter int ROWS = 61
) (
    input  logic        clk50,
    input  logic        rst_n,
    input  logic [7:0]  CharIn,
    input  logic [9:0]  AttrIn,
    input  logic        CharValid,
    output logic        CharReady,
    output logic [12:0] WAddr,
    output logic [17:0] WData,
    output logic        Write,
    output logic [6:0]  CursorCol,
    output logic [5:0]  CursorRow,
    output logic [2:0]  fsm_state
);
    typedef enum logic [2:0] {
        IDLE, SETUP, STROBE, ADVANCE, CLEAR_SETUP, CLEAR_STROBE
    } state_t;

    localparam logic [6:0]  COLS_M1 = 7'(COLS - 1);
    localparam logic [5:0]  ROWS_M1 = 6'(ROWS - 1);
    localparam logic [12:0] COLS_W  = 13'(COLS);
`ifdef XRC_LINE_CLEAR_EN
    localparam logic [12:0] CELLS_M1 = 13'(COLS * ROWS - 1);
`endif

    state_t      state, next_state;
    logic [7:0]  char_q;
    logic [12:0] line_base;
    logic [6:0]  col;
    logic [5:0]  row;
`ifdef XRC_LINE_CLEAR_EN
    logic [9:0]  attr_q;
    logic [12:0] clear_left;
`endif

    logic        in_print, q_print, row_adv, go_home, last_row;
    logic [5:0]  next_row;
    logic [12:0] next_base;

    // Handshake: a character transfers on a clk50 rising edge where CharValid and
    // CharReady are both 1; CharReady is 1 only in IDLE and never while rst_n is low.
    always_comb begin
        in_print  = (CharIn >= 8'h20) && (CharIn != 8'h7F);
        q_print   = (char_q >= 8'h20) && (char_q != 8'h7F);
        row_adv   = (q_print && (col == COLS_M1)) || (char_q == 8'h0A);
        go_home   = (char_q == 8'h0C);
        last_row  = (row == ROWS_M1);
        next_row  = last_row ? 6'd0 : row + 6'd1;
        next_base = last_row ? 13'd0 : line_base + COLS_W;
    end

    always_ff @(posedge clk50) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:         if (CharValid) next_state = in_print ? SETUP : ADVANCE;
            SETUP:        next_state = STROBE;
            STROBE:       next_state = ADVANCE;
`ifdef XRC_LINE_CLEAR_EN
            ADVANCE:      next_state = (row_adv || go_home) ? CLEAR_SETUP : IDLE;
            CLEAR_SETUP:  next_state = CLEAR_STROBE;
            CLEAR_STROBE: next_state = (clear_left == 13'd0) ? IDLE : CLEAR_SETUP;
`else
            ADVANCE:      next_state = IDLE;
`endif
            default:      next_state = IDLE;
        endcase
    end

    always_comb begin
        CharReady = rst_n && (state == IDLE);
        Write     = (state == STROBE) || (state == CLEAR_STROBE);
        fsm_state = state;
    end

    assign CursorCol = col;
    assign CursorRow = row;

    // Line base tracks row*COLS incrementally so the address needs only an adder.
    always_ff @(posedge clk50) begin
        if (!rst_n) begin
            char_q     <= '0;
            line_base  <= '0;
            col        <= '0;
            row        <= '0;
            WAddr      <= '0;
            WData      <= '0;
`ifdef XRC_LINE_CLEAR_EN
            attr_q     <= '0;
            clear_left <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (CharValid) begin
                    char_q <= CharIn;
`ifdef XRC_LINE_CLEAR_EN
                    attr_q <= AttrIn;
`endif
                    if (in_print) begin
                        WAddr <= line_base + {6'd0, col};
                        WData <= {AttrIn, CharIn};
                    end
                end
                ADVANCE: begin
                    if (row_adv) begin
                        col       <= '0;
                        row       <= next_row;
                        line_base <= next_base;
                    end else if (go_home) begin
                        col       <= '0;
                        row       <= '0;
                        line_base <= '0;
                    end else if (q_print) begin
                        col <= col + 7'd1;
                    end else if (char_q == 8'h0D) begin
                        col <= '0;
                    end else if ((char_q == 8'h08) && (col != 7'd0)) begin
                        col <= col - 7'd1;
                    end
`ifdef XRC_LINE_CLEAR_EN
                    if (row_adv) begin
                        WAddr      <= next_base;
                        WData      <= {attr_q, 8'h20};
                        clear_left <= COLS_W - 13'd1;
                    end else if (go_home) begin
                        WAddr      <= '0;
                        WData      <= {attr_q, 8'h20};
                        clear_left <= CELLS_M1;
                    end
`endif
                end
`ifdef XRC_LINE_CLEAR_EN
                CLEAR_STROBE: if (clear_left != 13'd0) begin
                    WAddr      <= WAddr + 13'd1;
                    clear_left <= clear_left - 13'd1;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_text_console_writer.sv
// Bench for text_console_writer: cell-level model with expected-write queue and cursor model.
// Define XRC_LINE_CLEAR_EN here as well to check the clearing build.
module tb_text_console_writer;
  localparam int COLS = 120;
  localparam int ROWS = 61;

  // clock / reset
  logic clk50 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk50 = ~clk50;

  logic [7:0]  CharIn = 8'h00;
  logic [9:0]  AttrIn = 10'h000;
  logic        CharValid = 1'b0;
  logic        CharReady;
  logic [12:0] WAddr;
  logic [17:0] WData;
  logic        Write;
  logic [6:0]  CursorCol;
  logic [5:0]  CursorRow;
  logic [2:0]  dbg_state;

  text_console_writer #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk50(clk50), .rst_n(rst_n), .CharIn(CharIn), .AttrIn(AttrIn),
    .CharValid(CharValid), .CharReady(CharReady), .WAddr(WAddr), .WData(WData),
    .Write(Write), .CursorCol(CursorCol), .CursorRow(CursorRow), .fsm_state(dbg_state)
  );

  int total = 0;
  int bad = 0;
  int write_cnt = 0;

  // expected writes: {is_char_write, addr[12:0], attr[9:0], char[7:0]}
  logic [31:0] exp_q[$];
  logic [31:0] exp_item;
  int m_col = 0;
  int m_row = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic finish_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting for the DUT", name);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // model: cursor and text-buffer writes from the character rules
  function automatic void model_apply(input logic [7:0] ch, input logic [9:0] attr);
    logic adv = 1'b0;
    if ((ch >= 8'h20) && (ch != 8'h7F)) begin
      exp_q.push_back({1'b1, 13'(m_row * COLS + m_col), attr, ch});
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        adv = 1'b1;
      end
    end else if (ch == 8'h0D) begin
      m_col = 0;
    end else if (ch == 8'h0A) begin
      m_col = 0;
      adv = 1'b1;
    end else if (ch == 8'h08) begin
      if (m_col > 0) m_col--;
    end else if (ch == 8'h0C) begin
      m_col = 0;
      m_row = 0;
`ifdef XRC_LINE_CLEAR_EN
      for (int a = 0; a < COLS * ROWS; a++) exp_q.push_back({1'b0, 13'(a), attr, 8'h20});
`endif
    end
    if (adv) begin
      m_row = (m_row + 1) % ROWS;
`ifdef XRC_LINE_CLEAR_EN
      for (int c = 0; c < COLS; c++) exp_q.push_back({1'b0, 13'(m_row * COLS + c), attr, 8'h20});
`endif
    end
  endfunction

  // scoreboard: every Write pulse against the expected queue, plus address/data stability
  logic        prev_write = 1'b0;
  logic        last_is_char = 1'b0;
  logic [12:0] prev_addr = '0;
  logic [17:0] prev_data = '0;

  always @(negedge clk50) begin
    if (!rst_n) begin
      prev_write = 1'b0;
      last_is_char = 1'b0;
    end else begin
      if (Write) begin
        write_cnt++;
        if (!prev_write) check("setup_stable", 32'({WAddr, WData}), 32'({prev_addr, prev_data}));
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got addr=%0d data=%0h, want no write", WAddr, WData);
        end else begin
          exp_item = exp_q.pop_front();
          last_is_char = exp_item[31];
          check("write_cell", 32'({WAddr, WData}), 32'(exp_item[30:0]));
        end
      end else if (prev_write && last_is_char) begin
        check("post_write_hold", 32'({WAddr, WData}), 32'({prev_addr, prev_data}));
      end
      prev_write = Write;
      prev_addr = WAddr;
      prev_data = WData;
    end
  end

  // driver tasks (called in the posedge+1 phase)
  task automatic send(input logic [7:0] ch, input logic [9:0] attr);
    int n = 0;
    while (CharReady !== 1'b1 && n < 20000) begin
      @(posedge clk50); #1;
      n++;
    end
    if (CharReady !== 1'b1) finish_now("send_ready");
    CharIn = ch;
    AttrIn = attr;
    CharValid = 1'b1;
    model_apply(ch, attr);
    @(posedge clk50); #1;
    CharValid = 1'b0;
    CharIn = 8'($urandom_range(0, 255));
    AttrIn = 10'($urandom_range(0, 1023));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (CharReady !== 1'b1 && n < 20000) begin
      @(posedge clk50); #1;
      n++;
    end
    if (CharReady !== 1'b1) finish_now({tag, "_idle"});
    check({tag, "_col"}, 32'(CursorCol), 32'(m_col));
    check({tag, "_row"}, 32'(CursorRow), 32'(m_row));
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    CharValid = 1'b0;
    exp_q.delete();
    m_col = 0;
    m_row = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk50); #1;
      check("rst_write", 32'(Write), 32'd0);
      check("rst_ready", 32'(CharReady), 32'd0);
      if (i == 0) begin
        check("rst_waddr", 32'(WAddr), 32'd0);
        check("rst_wdata", 32'(WData), 32'd0);
        check("rst_col", 32'(CursorCol), 32'd0);
        check("rst_row", 32'(CursorRow), 32'd0);
      end
    end
    rst_n = 1'b1;
    #1;
    check("ready_after_rst", 32'(CharReady), 32'd1);
  endtask

  initial begin
    #5_000_000;
    finish_now("global");
  end

  int wc0;
  int n;

  initial begin
    do_reset(3);

    // 'A' at (0,0): exact pulse timing
    send(8'h41, 10'h0F0);
    check("a_p1_write", 32'(Write), 32'd0);
    check("a_p1_ready", 32'(CharReady), 32'd0);
    @(posedge clk50); #1;
    check("a_p2_write", 32'(Write), 32'd1);
    check("a_waddr", 32'(WAddr), 32'd0);
    check("a_wdata", 32'(WData), 32'h0F041);
    @(posedge clk50); #1;
    check("a_p3_write", 32'(Write), 32'd0);
    check("a_p3_ready", 32'(CharReady), 32'd0);
    @(posedge clk50); #1;
    check("a_p4_ready", 32'(CharReady), 32'd1);
    wait_idle("a");
    check("a_col_lit", 32'(CursorCol), 32'd1);

    // offered char while busy, withdrawn before ready: must be ignored
    send(8'h4D, 10'h011);
    CharIn = 8'h0C;
    CharValid = 1'b1;
    @(posedge clk50); #1;
    CharValid = 1'b0;
    wait_idle("junk");
    check("junk_col_lit", 32'(CursorCol), 32'd2);

    // backspace down to column 0 and once more at the edge
    for (int i = 0; i < 3; i++) begin
      send(8'h08, 10'h000);
      wait_idle("bs");
    end
    check("bs_col_lit", 32'(CursorCol), 32'd0);

    // fill row 0 up to the last column, then wrap with 'Z'
    for (int i = 0; i < COLS - 1; i++) begin
      send(8'h61 + 8'(i % 26), 10'(i * 37));
      wait_idle("fill");
    end
    check("fill_col_lit", 32'(CursorCol), 32'd119);
    wc0 = write_cnt;
    send(8'h5A, 10'h3A5);
    wait_idle("wrap");
    check("wrap_col_lit", 32'(CursorCol), 32'd0);
    check("wrap_row_lit", 32'(CursorRow), 32'd1);
`ifdef XRC_LINE_CLEAR_EN
    check("wrap_writes", 32'(write_cnt - wc0), 32'd121);
`else
    check("wrap_writes", 32'(write_cnt - wc0), 32'd1);
`endif

    // walk to (5,60), then LF wraps to row 0
    for (int i = 0; i < ROWS - 2; i++) begin
      send(8'h0A, 10'(i));
      wait_idle("lf");
    end
    for (int i = 0; i < 5; i++) begin
      send(8'h30 + 8'(i), 10'h0C3);
      wait_idle("row60");
    end
    check("r60_col_lit", 32'(CursorCol), 32'd5);
    check("r60_row_lit", 32'(CursorRow), 32'd60);
    wc0 = write_cnt;
    send(8'h0A, 10'h1E7);
    wait_idle("lfwrap");
    check("lfwrap_col_lit", 32'(CursorCol), 32'd0);
    check("lfwrap_row_lit", 32'(CursorRow), 32'd0);
`ifdef XRC_LINE_CLEAR_EN
    check("lfwrap_writes", 32'(write_cnt - wc0), 32'd120);
`else
    check("lfwrap_writes", 32'(write_cnt - wc0), 32'd0);
`endif

    // printable/control boundaries: 0x80, 0xFF, 0x7F, 0x1F, 0x20
    send(8'h80, 10'h001); wait_idle("c80");
    send(8'hFF, 10'h002); wait_idle("cff");
    send(8'h7F, 10'h003); wait_idle("c7f");
    send(8'h1F, 10'h004); wait_idle("c1f");
    send(8'h20, 10'h005); wait_idle("c20");
    check("bound_col_lit", 32'(CursorCol), 32'd3);

    // CR then LF x3 to (0,3); BS, CR, BEL leave it there with no writes
    send(8'h0D, 10'h000); wait_idle("cr");
    for (int i = 0; i < 3; i++) begin
      send(8'h0A, 10'h0AA);
      wait_idle("lf3");
    end
    wc0 = write_cnt;
    send(8'h08, 10'h000); wait_idle("bs03");
    send(8'h0D, 10'h000); wait_idle("cr03");
    send(8'h07, 10'h000); wait_idle("bel03");
    check("ctl_col_lit", 32'(CursorCol), 32'd0);
    check("ctl_row_lit", 32'(CursorRow), 32'd3);
    check("ctl_writes", 32'(write_cnt - wc0), 32'd0);

`ifdef XRC_LINE_CLEAR_EN
    // form feed clear aborted by reset after 50 cells
    wc0 = write_cnt;
    send(8'h0C, 10'h155);
    n = 0;
    while ((write_cnt - wc0) < 50 && n < 1000) begin
      @(posedge clk50); #1;
      n++;
    end
    check("ff_clear_count", 32'(write_cnt - wc0), 32'd50);
    do_reset(3);
`else
    // form feed only homes the cursor
    wc0 = write_cnt;
    send(8'h0C, 10'h155);
    wait_idle("ff");
    check("ff_col_lit", 32'(CursorCol), 32'd0);
    check("ff_row_lit", 32'(CursorRow), 32'd0);
    check("ff_writes", 32'(write_cnt - wc0), 32'd0);
    // reset while a character write is in SETUP: pending write dropped
    send(8'h09, 10'h000); wait_idle("tab");
    send(8'h51, 10'h2AA);
    do_reset(3);
`endif

    // normal operation after reset
    send(8'h6B, 10'h001);
    wait_idle("post");
    check("post_col_lit", 32'(CursorCol), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
